score_keeper: RTL and testbench

Parametrised two-player score and serve tracker for the pong game, replacing the fixed first-to-11 counter. Accepts level or pulse point requests from the ball/collision logic and edge-detects them. Applies a configurable win threshold with win-by margin, saturates scores, and rotates serve. Drives registered BCD digits for the HEX displays and the win flags used by the top-level game controller.

---
 rtl/score_keeper.sv | 174 +++++++++++++++++
 tb/tb_score_keeper.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Two-player pong score/serve tracker with win-by margin,
//             saturation, serve rotation, deuce tracking and BCD outputs.
//  Revision : 1.0
// ============================================================================
module score_keeper #(
    parameter int SCORE_WIDTH      = 5,
    parameter int WIN_SCORE        = 11,
    parameter int WIN_BY           = 2,
    parameter int SERVE_SWAP       = 2,
    parameter int FIRST_SERVE_LEFT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   point_left,
    input  logic                   point_right,
    input  logic                   new_game,
    output logic [SCORE_WIDTH-1:0] left_score,
    output logic [SCORE_WIDTH-1:0] right_score,
    output logic [7:0]             left_bcd,
    output logic [7:0]             right_bcd,
    output logic                   serve_left,
    output logic                   deuce,
    output logic                   left_won,
    output logic                   right_won,
    output logic                   game_over_pulse
);

    localparam int CNT_W = (SERVE_SWAP < 2) ? 1 : $clog2(SERVE_SWAP + 1);

    localparam logic [SCORE_WIDTH-1:0] c_max_score = '1;
    localparam logic [SCORE_WIDTH:0]   c_win       = (SCORE_WIDTH+1)'(WIN_SCORE);
    localparam logic [SCORE_WIDTH:0]   c_win_m1    = (SCORE_WIDTH+1)'(WIN_SCORE - 1);
    localparam logic [SCORE_WIDTH:0]   c_win_by    = (SCORE_WIDTH+1)'(WIN_BY);
    localparam logic [CNT_W-1:0]       c_swap      = CNT_W'(SERVE_SWAP);
    localparam logic                   c_first     = (FIRST_SERVE_LEFT != 0);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_DEUCE = 2'd1,
        ST_WON   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SCORE_WIDTH-1:0] left_q, left_d;
    logic [SCORE_WIDTH-1:0] right_q, right_d;
    logic [7:0]             lbcd_q, rbcd_q;
    logic                   serve_q, serve_d;
    logic                   first_q, first_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wonl_q, wonl_d;
    logic                   wonr_q, wonr_d;
    logic                   pulse_q, pulse_d;
    logic                   pl_q, pr_q, ng_q;

    logic                   w_ev_l, w_ev_r, w_accept;
    logic [SCORE_WIDTH-1:0] w_nl, w_nr;
    logic [SCORE_WIDTH:0]   w_nl_x, w_nr_x;
    logic                   w_win_l, w_win_r, w_near;
    logic [CNT_W-1:0]       w_cnt_inc;

    function automatic logic [7:0] to_bcd(input logic [SCORE_WIDTH-1:0] s);
        logic [7:0] v;
        v      = 8'(s);
        to_bcd = {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    // Candidate next scores; the margin is only meaningful when scorer leads.
    always_comb begin
        w_ev_l    = point_left  & ~pl_q;
        w_ev_r    = point_right & ~pr_q;
        w_accept  = (w_ev_l ^ w_ev_r) && (state_q != ST_WON);
        w_nl      = (w_ev_l && left_q  != c_max_score) ? left_q  + 1'b1 : left_q;
        w_nr      = (w_ev_r && right_q != c_max_score) ? right_q + 1'b1 : right_q;
        w_nl_x    = {1'b0, w_nl};
        w_nr_x    = {1'b0, w_nr};
        w_win_l   = w_ev_l && (((w_nl_x >= c_win) && (w_nl_x > w_nr_x) &&
                                ((w_nl_x - w_nr_x) >= c_win_by)) || (w_nl == c_max_score));
        w_win_r   = w_ev_r && (((w_nr_x >= c_win) && (w_nr_x > w_nl_x) &&
                                ((w_nr_x - w_nl_x) >= c_win_by)) || (w_nr == c_max_score));
        w_near    = (w_nl_x >= c_win_m1) && (w_nr_x >= c_win_m1);
        w_cnt_inc = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        serve_d = serve_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        wonl_d  = wonl_q;
        wonr_d  = wonr_q;
        pulse_d = 1'b0;

        if (new_game) begin
            // Held new_game keeps the block cleared; server flips once.
            state_d = ST_PLAY;
            left_d  = '0;
            right_d = '0;
            cnt_d   = '0;
            wonl_d  = 1'b0;
            wonr_d  = 1'b0;
            first_d = ng_q ? first_q : ~first_q;
            serve_d = first_d;
        end else if (w_accept) begin
            left_d  = w_nl;
            right_d = w_nr;
            if (w_win_l || w_win_r) begin
                state_d = ST_WON;
                wonl_d  = w_win_l;
                wonr_d  = w_win_r;
                pulse_d = 1'b1;
            end else if (state_q == ST_DEUCE || w_near) begin
                state_d = ST_DEUCE;
                serve_d = ~serve_q;
                cnt_d   = '0;
            end else if (w_cnt_inc == c_swap) begin
                serve_d = ~serve_q;
                cnt_d   = '0;
            end else begin
                cnt_d   = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_PLAY;
            left_q  <= '0;
            right_q <= '0;
            lbcd_q  <= 8'h00;
            rbcd_q  <= 8'h00;
            serve_q <= c_first;
            first_q <= c_first;
            cnt_q   <= '0;
            wonl_q  <= 1'b0;
            wonr_q  <= 1'b0;
            pulse_q <= 1'b0;
            pl_q    <= 1'b0;
            pr_q    <= 1'b0;
            ng_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            lbcd_q  <= to_bcd(left_q);
            rbcd_q  <= to_bcd(right_q);
            serve_q <= serve_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            wonl_q  <= wonl_d;
            wonr_q  <= wonr_d;
            pulse_q <= pulse_d;
            pl_q    <= point_left;
            pr_q    <= point_right;
            ng_q    <= new_game;
        end
    end

    assign left_score      = left_q;
    assign right_score     = right_q;
    assign left_bcd        = lbcd_q;
    assign right_bcd       = rbcd_q;
    assign serve_left      = serve_q;
    assign deuce           = (state_q == ST_DEUCE);
    assign left_won        = wonl_q;
    assign right_won       = wonr_q;
    assign game_over_pulse = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Scoreboard bench for score_keeper (5-bit and 4-bit instances).
//  Revision : 1.0
// ============================================================================
module tb_score_keeper;

    typedef struct {
        int ls, rs, lb, rb, sv, dc, wl, wr, pu;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_pl = 1'b0, i_pr = 1'b0, i_ng = 1'b0;

    logic [4:0] d5_ls, d5_rs;
    logic [3:0] d4_ls, d4_rs;
    logic [7:0] d5_lb, d5_rb, d4_lb, d4_rb;
    logic d5_sv, d5_dc, d5_wl, d5_wr, d5_pu;
    logic d4_sv, d4_dc, d4_wl, d4_wr, d4_pu;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, index 0 = 5-bit instance, 1 = 4-bit instance.
    int m_ls[2], m_rs[2], m_lb[2], m_rb[2], m_first[2];
    int m_np[2], m_dp[2], m_wl[2], m_wr[2], m_dc[2], m_pu[2];
    int m_pl, m_pr, m_ng;
    int mx[2] = '{31, 15};

    score_keeper u_dut5 (
        .clock(clk), .reset(rst), .point_left(i_pl), .point_right(i_pr), .new_game(i_ng),
        .left_score(d5_ls), .right_score(d5_rs), .left_bcd(d5_lb), .right_bcd(d5_rb),
        .serve_left(d5_sv), .deuce(d5_dc), .left_won(d5_wl), .right_won(d5_wr),
        .game_over_pulse(d5_pu)
    );

    score_keeper #(.SCORE_WIDTH(4)) u_dut4 (
        .clock(clk), .reset(rst), .point_left(i_pl), .point_right(i_pr), .new_game(i_ng),
        .left_score(d4_ls), .right_score(d4_rs), .left_bcd(d4_lb), .right_bcd(d4_rb),
        .serve_left(d4_sv), .deuce(d4_dc), .left_won(d4_wl), .right_won(d4_wr),
        .game_over_pulse(d4_pu)
    );

    always #5 clk = ~clk;

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, got, exp);
        end
    endtask

    function automatic exp_t expected(input int k);
        exp_t e;
        e.ls = m_ls[k]; e.rs = m_rs[k]; e.lb = m_lb[k]; e.rb = m_rb[k];
        // Serve flips every SERVE_SWAP normal points plus once per deuce point.
        e.sv = m_first[k] ^ ((m_np[k] / 2) & 1) ^ (m_dp[k] & 1);
        e.dc = m_dc[k]; e.wl = m_wl[k]; e.wr = m_wr[k]; e.pu = m_pu[k];
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ls[k] = 0; m_rs[k] = 0; m_lb[k] = 0; m_rb[k] = 0; m_first[k] = 1;
            m_np[k] = 0; m_dp[k] = 0; m_wl[k] = 0; m_wr[k] = 0; m_dc[k] = 0; m_pu[k] = 0;
        end
        m_pl = 0; m_pr = 0; m_ng = 0;
    endtask

    task automatic model_step(input int k, input int pli, input int pri, input int ngi);
        int evl, evr, nl, nr, win;
        evl = pli & ~m_pl & 1;
        evr = pri & ~m_pr & 1;
        m_lb[k] = bcd(m_ls[k]);
        m_rb[k] = bcd(m_rs[k]);
        m_pu[k] = 0;
        if (ngi != 0) begin
            if (m_ng == 0) m_first[k] = 1 - m_first[k];
            m_ls[k] = 0; m_rs[k] = 0; m_np[k] = 0; m_dp[k] = 0;
            m_wl[k] = 0; m_wr[k] = 0; m_dc[k] = 0;
        end else if (evl != evr && m_wl[k] == 0 && m_wr[k] == 0) begin
            nl = m_ls[k] + evl;
            nr = m_rs[k] + evr;
            if (evl != 0) win = ((nl >= 11 && nl - nr >= 2) || nl == mx[k]) ? 1 : 0;
            else          win = ((nr >= 11 && nr - nl >= 2) || nr == mx[k]) ? 1 : 0;
            if (win != 0) begin
                m_wl[k] = evl; m_wr[k] = evr; m_pu[k] = 1; m_dc[k] = 0;
            end else if (m_dc[k] != 0 || (nl >= 10 && nr >= 10)) begin
                m_dc[k] = 1; m_dp[k]++;
            end else begin
                m_np[k]++;
            end
            m_ls[k] = nl; m_rs[k] = nr;
        end
    endtask

    task automatic step(input int pli, input int pri, input int ngi);
        @(posedge clk);
        #2;
        i_pl = pli[0]; i_pr = pri[0]; i_ng = ngi[0];
        model_step(0, pli, pri, ngi);
        model_step(1, pli, pri, ngi);
        m_pl = pli; m_pr = pri; m_ng = ngi;
        q0.push_back(expected(0));
        q1.push_back(expected(1));
    endtask

    task automatic pulse(input int left);
        if (left != 0) step(1, 0, 0); else step(0, 1, 0);
        step(0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #5;
        rst = 1'b1;
        i_pl = 1'b0; i_pr = 1'b0; i_ng = 1'b0;
        #1;
        chk("rst_ls5", int'(d5_ls), 0); chk("rst_rs5", int'(d5_rs), 0);
        chk("rst_lb5", int'(d5_lb), 0); chk("rst_rb5", int'(d5_rb), 0);
        chk("rst_sv5", int'(d5_sv), 1); chk("rst_dc5", int'(d5_dc), 0);
        chk("rst_wl5", int'(d5_wl), 0); chk("rst_wr5", int'(d5_wr), 0);
        chk("rst_pu5", int'(d5_pu), 0);
        chk("rst_ls4", int'(d4_ls), 0); chk("rst_sv4", int'(d4_sv), 1);
        chk("rst_wl4", int'(d4_wl), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic compare(input string tag, input exp_t e, input exp_t a);
        chk({tag, "_left_score"},  a.ls, e.ls);
        chk({tag, "_right_score"}, a.rs, e.rs);
        chk({tag, "_left_bcd"},    a.lb, e.lb);
        chk({tag, "_right_bcd"},   a.rb, e.rb);
        chk({tag, "_serve_left"},  a.sv, e.sv);
        chk({tag, "_deuce"},       a.dc, e.dc);
        chk({tag, "_left_won"},    a.wl, e.wl);
        chk({tag, "_right_won"},   a.wr, e.wr);
        chk({tag, "_pulse"},       a.pu, e.pu);
    endtask

    // Monitor: each queued expectation describes the state after one edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a.ls = int'(d5_ls); a.rs = int'(d5_rs); a.lb = int'(d5_lb); a.rb = int'(d5_rb);
                a.sv = int'(d5_sv); a.dc = int'(d5_dc); a.wl = int'(d5_wl); a.wr = int'(d5_wr);
                a.pu = int'(d5_pu);
                compare("w5", e, a);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a.ls = int'(d4_ls); a.rs = int'(d4_rs); a.lb = int'(d4_lb); a.rb = int'(d4_rb);
                a.sv = int'(d4_sv); a.dc = int'(d4_dc); a.wl = int'(d4_wl); a.wr = int'(d4_wr);
                a.pu = int'(d4_pu);
                compare("w4", e, a);
            end
        end
    end

    initial begin
        int r;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Straight win, then an ignored extra point.
        for (int i = 0; i < 12; i++) pulse(1);
        repeat (2) step(0, 0, 0);

        do_reset();
        pulse(1); pulse(0); pulse(1); pulse(0);

        do_reset();
        for (int i = 0; i < 10; i++) begin pulse(1); pulse(0); end
        pulse(1); pulse(0); pulse(1); pulse(1);
        step(0, 0, 0);

        // Held level, simultaneous edges, new_game colliding with a point.
        step(0, 0, 1); step(0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 1, 0);
        step(0, 0, 0);
        step(1, 1, 0); step(0, 0, 0);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 0);

        // Long deuce: 4-bit instance wins by saturation at 15-14.
        do_reset();
        for (int i = 0; i < 14; i++) begin pulse(1); pulse(0); end
        pulse(1); pulse(1); pulse(0); pulse(1);
        step(0, 0, 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) do_reset();
            else step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), (r < 30) ? 1 : 0);
        end

        repeat (3) @(posedge clk);
        #3;
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
